// File: rtl/uart_pkg.sv
// Shared state encoding and line-level constants for the UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   FRAME_BITS = 10;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_bit_tick,
  output logic o_pre_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear || o_bit_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // o_pre_tick lets the parent register outputs that must line up with the last cycle.
  assign o_bit_tick = (r_count == LAST_CNT);
  assign o_pre_tick = (r_count == PRE_CNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit; outputs fully registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_sent,
  input  logic                 tx_start,
  output logic                 tx_waveform,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_t          r_state;
  uart_state_t          w_nextState;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_nextShift;
  logic [IDX_W-1:0]     r_bitIdx;
  logic [IDX_W-1:0]     w_nextBitIdx;
  logic                 r_line;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_nextLine;
  logic                 w_nextDone;
  logic                 w_bitTick;
  logic                 w_preTick;
  logic                 w_clear;

  // Holding the divider clear in IDLE makes every frame start on a fresh bit period.
  assign w_clear = (r_state == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .o_bit_tick(w_bitTick),
    .o_pre_tick(w_preTick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitIdx <= '0;
      r_line   <= IDLE_LEVEL;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_shift  <= w_nextShift;
      r_bitIdx <= w_nextBitIdx;
      r_line   <= w_nextLine;
      r_busy   <= (w_nextState != IDLE);
      r_done   <= w_nextDone;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextShift  = r_shift;
    w_nextBitIdx = r_bitIdx;
    case (r_state)
      IDLE: begin
        if (tx_start) begin
          w_nextState = START;
          w_nextShift = data_sent;
        end
      end
      START: begin
        if (w_bitTick) w_nextState = DATA;
      end
      DATA: begin
        if (w_bitTick) begin
          w_nextShift = r_shift >> 1;
          if (r_bitIdx == LAST_IDX) begin
            w_nextState  = STOP;
            w_nextBitIdx = '0;
          end else begin
            w_nextBitIdx = r_bitIdx + IDX_W'(1);
          end
        end
      end
      STOP: begin
        // A request in the final stop cycle chains straight into the next start bit.
        if (w_bitTick) begin
          if (tx_start) begin
            w_nextState = START;
            w_nextShift = data_sent;
          end else begin
            w_nextState = IDLE;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase

    // Line level and done flag are computed for the coming cycle so they can be registered.
    case (w_nextState)
      START:   w_nextLine = START_BIT;
      DATA:    w_nextLine = w_nextShift[0];
      STOP:    w_nextLine = STOP_BIT;
      default: w_nextLine = IDLE_LEVEL;
    endcase
    w_nextDone = (r_state == STOP) && w_preTick;
  end

  assign tx_waveform = r_line;
  assign tx_busy     = r_busy;
  assign tx_done     = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle line checks plus a mid-bit decoder feeding a byte scoreboard.
module tb_uart_tx;

  localparam int CPB_A   = 4;
  localparam int CPB_B   = 16;
  localparam int FRAME_A = 10 * CPB_A;
  localparam int FRAME_B = 10 * CPB_B;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dataA, dataB;
  logic       startA, startB;
  logic       txA, busyA, doneA;
  logic       txB, busyB, doneB;

  int         compareCount  = 0;
  int         mismatchCount = 0;
  logic [7:0] expQ[$];
  bit         monEnable = 1'b0;
  bit         activity;
  int         firstLow, lastBusy;

  uart_tx #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8)) dutA (
    .clk(clk), .rst(rst), .data_sent(dataA), .tx_start(startA),
    .tx_waveform(txA), .tx_busy(busyA), .tx_done(doneA)
  );

  uart_tx #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(8)) dutB (
    .clk(clk), .rst(rst), .data_sent(dataB), .tx_start(startB),
    .tx_waveform(txB), .tx_busy(busyB), .tx_done(doneB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference line level at 1-based cycle pos within a frame.
  function automatic logic expLevel(input logic [7:0] d, input int pos, input int cpb);
    int b;
    b = (pos - 1) / cpb;
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return d[b-1];
  endfunction

  // Drives one frame (or two chained frames) on dutA and checks every cycle against the model.
  task automatic applyStimulus(input logic [7:0] d0, input logic [7:0] d1, input bit backToBack,
                               input bit busyPoke, input int idleCycles);
    int         nFrames;
    int         pos;
    logic [7:0] d;
    nFrames = backToBack ? 2 : 1;
    @(negedge clk);
    dataA  = d0;
    startA = 1'b1;
    expQ.push_back(d0);
    for (int k = 1; k <= nFrames * FRAME_A + idleCycles; k++) begin
      @(negedge clk);
      if (k <= nFrames * FRAME_A) begin
        pos = (k - 1) % FRAME_A + 1;
        d   = (k > FRAME_A) ? d1 : d0;
        checkOutput($sformatf("%02h line c%0d", d, k), txA, expLevel(d, pos, CPB_A));
        checkOutput($sformatf("%02h busy c%0d", d, k), busyA, 1);
        checkOutput($sformatf("%02h done c%0d", d, k), doneA, (pos == FRAME_A));
      end else begin
        checkOutput($sformatf("%02h idle line c%0d", d0, k), txA, 1);
        checkOutput($sformatf("%02h idle busy c%0d", d0, k), busyA, 0);
        checkOutput($sformatf("%02h idle done c%0d", d0, k), doneA, 0);
      end
      startA = 1'b0;
      if (backToBack) begin
        if (k == 1) dataA = d1;
        if (k < FRAME_A) startA = 1'b1;
        if (k == FRAME_A) begin
          startA = 1'b1;
          expQ.push_back(d1);
        end
      end else if (busyPoke && k == 3 * CPB_A + 2) begin
        startA = 1'b1;
        dataA  = ~d0;
      end
    end
  endtask

  // Mid-bit decoder on dutA; each recovered byte is matched against the scoreboard.
  initial begin : monitor
    logic [7:0] got;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (monEnable && txA === 1'b0) begin
        repeat (CPB_A / 2) @(negedge clk);
        checkOutput("mon start bit", txA, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB_A) @(negedge clk);
          got[i] = txA;
        end
        repeat (CPB_A) @(negedge clk);
        checkOutput("mon stop bit", txA, 1);
        checkOutput("mon frame was expected", (expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
          want = expQ.pop_front();
          checkOutput("mon decoded byte", got, want);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; startA = 1'b0; startB = 1'b0; dataA = 8'h00; dataB = 8'h00;
    #1;
    checkOutput("reset line", txA, 1);
    checkOutput("reset busy", busyA, 0);
    checkOutput("reset done", doneA, 0);
    checkOutput("reset line B", txB, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    monEnable = 1'b1;

    // Reset pulse while idle, checked before any clock edge.
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("idle rst line", txA, 1);
    checkOutput("idle rst busy", busyA, 0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(8'h1E, 8'h00, 1'b0, 1'b0, 3);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 3);
    applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 3);
    applyStimulus(8'hA5, 8'h3C, 1'b1, 1'b0, 3);
    applyStimulus(8'h5A, 8'h00, 1'b0, 1'b1, 20);

    // Abort during data bit 3 of an all-zero byte so the line is low beforehand.
    monEnable = 1'b0;
    @(negedge clk);
    dataA  = 8'h00;
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    repeat (4 * CPB_A + 1) @(negedge clk);
    checkOutput("abort pre line", txA, 0);
    checkOutput("abort pre busy", busyA, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort rst line", txA, 1);
    checkOutput("abort rst busy", busyA, 0);
    checkOutput("abort rst done", doneA, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    activity = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (txA !== 1'b1 || busyA !== 1'b0 || doneA !== 1'b0) activity = 1'b1;
    end
    checkOutput("abort quiet after release", activity, 0);
    monEnable = 1'b1;

    // Divider check on the 16-clock instance.
    @(negedge clk);
    dataB  = 8'h96;
    startB = 1'b1;
    firstLow = -1;
    lastBusy = -1;
    for (int k = 1; k <= FRAME_B + 4; k++) begin
      @(negedge clk);
      startB = 1'b0;
      if (k <= FRAME_B) begin
        checkOutput($sformatf("B line c%0d", k), txB, expLevel(8'h96, k, CPB_B));
        checkOutput($sformatf("B done c%0d", k), doneB, (k == FRAME_B));
      end
      if (txB === 1'b0 && firstLow < 0) firstLow = k;
      if (busyB === 1'b1) lastBusy = k;
    end
    checkOutput("B start latency", firstLow, 1);
    checkOutput("B frame length", lastBusy - firstLow + 1, FRAME_B);
    checkOutput("B idle after", busyB, 0);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
